// File: rtl/mips32_fetch_queue.sv
// mips32_fetch_queue: instruction fetch front end feeding decode through a show-ahead FIFO
module mips32_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic              clk1,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              halt,
  output logic              out_valid,
  output logic [31:0]       out_ir,
  output logic [31:0]       out_npc,
  input  logic              out_ready,
  output logic [31:0]       pc
);
  localparam int PW = $clog2(DEPTH);
  logic [31:0]   ir_mem  [DEPTH];
  logic [31:0]   npc_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [31:0]   npc_q;
  logic          inflight, stopped;
  logic          hlt_ret, enq, deq;
  assign hlt_ret   = inflight & (imem_rdata[31:26] == 6'b111111);
  assign enq       = inflight & ~redirect;
  assign deq       = out_valid & out_ready & ~redirect;
  assign out_valid = (count != '0);
  assign out_ir    = ir_mem[rd_ptr];
  assign out_npc   = npc_mem[rd_ptr];
  assign imem_addr = pc[ADDR_W-1:0];
  // Issue only when a slot is guaranteed for the reply; an HLT coming back blocks the next request.
  assign imem_req  = rst_n & ~redirect & ~halt & ~stopped & ~hlt_ret &
                     ((count + {{PW{1'b0}}, inflight}) < (PW+1)'(DEPTH));
  // FIFO storage: returning word tagged with the NPC captured at issue time
  always_ff @(posedge clk1) begin
    if (enq) begin
      ir_mem[wr_ptr]  <= imem_rdata;
      npc_mem[wr_ptr] <= npc_q;
    end
  end
  // PC, in-flight tracking, HLT stop and FIFO bookkeeping; redirect flushes everything
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      npc_q    <= '0;
      inflight <= 1'b0;
      stopped  <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
      stopped  <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        pc    <= pc + 32'd1;
        npc_q <= pc + 32'd1;
      end
      if (hlt_ret) stopped <= 1'b1;
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, enq} - {{PW{1'b0}}, deq};
    end
  end
endmodule

// File: tb/tb_mips32_fetch_queue.sv
// tb_mips32_fetch_queue: vector table plus scoreboard checks for the fetch queue
module tb_mips32_fetch_queue;
  localparam int ADDR_W = 10;
  logic              clk1 = 1'b0, rst_n = 1'b0;
  logic              imem_req, redirect = 1'b0, halt = 1'b0, out_ready = 1'b0, out_valid;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata = '0, redirect_pc = '0, out_ir, out_npc, pc;
  int                n_vec = 0, n_bad = 0;
  bit                sb_on = 0, hlt_en = 0;
  logic [ADDR_W-1:0] hlt_addr = '0;
  logic [63:0]       sb[$];

  typedef struct {
    bit rdy; bit rd; logic [31:0] rpc;
    bit req; bit v; logic [31:0] ir; logic [31:0] npc; logic [31:0] pc;
  } vec_t;
  vec_t tbl[15];

  mips32_fetch_queue #(.DEPTH(4), .ADDR_W(ADDR_W), .RESET_PC(32'd0)) dut (
    .clk1(clk1), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .out_valid(out_valid), .out_ir(out_ir), .out_npc(out_npc),
    .out_ready(out_ready), .pc(pc)
  );

  always #5 clk1 = ~clk1;

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return (hlt_en && a == hlt_addr) ? 32'hFC00_0000 : 32'h1000_0000 + 32'(a);
  endfunction

  always @(posedge clk1) if (imem_req) imem_rdata <= mem_word(imem_addr);

  function automatic vec_t mk(bit rdy, bit rd, logic [31:0] rpc, bit req, bit v,
                              logic [31:0] ir, logic [31:0] npc, logic [31:0] p);
    vec_t t;
    t.rdy = rdy; t.rd = rd; t.rpc = rpc; t.req = req; t.v = v; t.ir = ir; t.npc = npc; t.pc = p;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] ir, input logic [31:0] npc);
    sb.push_back({ir, npc});
  endtask

  task automatic sb_check();
    logic [63:0] e;
    if (sb_on && out_valid && out_ready && !redirect) begin
      if (sb.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL sb_extra: got ir %h npc %h expected no word", out_ir, out_npc);
      end else begin
        e = sb.pop_front();
        chk("sb_ir", out_ir, e[63:32]);
        chk("sb_npc", out_npc, e[31:0]);
      end
    end
  endtask

  task automatic tick(input bit rdy, input bit rd, input logic [31:0] rpc, input bit hl);
    @(negedge clk1);
    out_ready = rdy; redirect = rd; redirect_pc = rpc; halt = hl;
    #1;
    sb_check();
  endtask

  task automatic do_reset();
    @(negedge clk1);
    rst_n = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    sb.delete();
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    @(posedge clk1);
    #2 rst_n = 1'b1;
  endtask

  task automatic apply_vec(input int i);
    tick(tbl[i].rdy, tbl[i].rd, tbl[i].rpc, 1'b0);
    chk($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].req});
    chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].v});
    chk($sformatf("v%0d_pc", i), pc, tbl[i].pc);
    chk($sformatf("v%0d_addr", i), {22'b0, imem_addr}, {22'b0, tbl[i].pc[ADDR_W-1:0]});
    if (tbl[i].v) begin
      chk($sformatf("v%0d_ir", i), out_ir, tbl[i].ir);
      chk($sformatf("v%0d_npc", i), out_npc, tbl[i].npc);
    end
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0, 1, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 1, 0, 0, 0, 1);
    tbl[2]  = mk(1, 0, 0, 1, 1, 32'h1000_0000, 1, 2);
    tbl[3]  = mk(1, 0, 0, 1, 1, 32'h1000_0001, 2, 3);
    tbl[4]  = mk(1, 0, 0, 1, 1, 32'h1000_0002, 3, 4);
    tbl[5]  = mk(1, 0, 0, 1, 1, 32'h1000_0003, 4, 5);
    tbl[6]  = mk(0, 0, 0, 1, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 1, 0, 0, 0, 1);
    tbl[8]  = mk(0, 0, 0, 1, 1, 32'h1000_0000, 1, 2);
    tbl[9]  = mk(0, 0, 0, 1, 1, 32'h1000_0000, 1, 3);
    tbl[10] = mk(0, 1, 32'h40, 0, 1, 32'h1000_0000, 1, 4);
    tbl[11] = mk(0, 0, 0, 1, 0, 0, 0, 32'h40);
    tbl[12] = mk(0, 0, 0, 1, 0, 0, 0, 32'h41);
    tbl[13] = mk(0, 0, 0, 1, 1, 32'h1000_0040, 32'h41, 32'h42);
    tbl[14] = mk(0, 0, 0, 1, 1, 32'h1000_0040, 32'h41, 32'h43);

    // startup latency and streaming
    do_reset();
    for (int i = 0; i < 6; i++) apply_vec(i);

    // redirect with three words buffered and one in flight
    do_reset();
    for (int i = 6; i < 15; i++) apply_vec(i);

    // backpressure fills exactly DEPTH words, then drains with no gap
    do_reset();
    sb_on = 1;
    for (int k = 0; k < 12; k++) push(32'h1000_0000 + 32'(k), 32'(k + 1));
    repeat (10) tick(0, 0, 0, 0);
    chk("bp_req", {31'b0, imem_req}, 32'd0);
    chk("bp_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_pc", pc, 32'd4);
    chk("bp_head", out_ir, 32'h1000_0000);
    for (int k = 0; k < 12; k++) begin
      tick(1, 0, 0, 0);
      chk("bp_nogap", {31'b0, out_valid}, 32'd1);
    end
    chk("bp_left", 32'(sb.size()), 32'd0);

    // HLT at address 2 stops fetching; redirect restarts
    hlt_en = 1; hlt_addr = 10'd2;
    do_reset();
    push(32'h1000_0000, 1); push(32'h1000_0001, 2); push(32'hFC00_0000, 3);
    repeat (3) tick(1, 0, 0, 0);
    repeat (7) begin
      tick(1, 0, 0, 0);
      chk("hlt_req", {31'b0, imem_req}, 32'd0);
    end
    chk("hlt_left", 32'(sb.size()), 32'd0);
    chk("hlt_pc", pc, 32'd3);
    chk("hlt_valid", {31'b0, out_valid}, 32'd0);
    push(32'h1000_0000, 1); push(32'h1000_0001, 2); push(32'hFC00_0000, 3);
    tick(1, 1, 32'd0, 0);
    tick(1, 0, 0, 0);
    chk("hlt_rs_req", {31'b0, imem_req}, 32'd1);
    chk("hlt_rs_addr", {22'b0, imem_addr}, 32'd0);
    repeat (7) tick(1, 0, 0, 0);
    chk("hlt_rs_left", 32'(sb.size()), 32'd0);
    chk("hlt_rs_pc", pc, 32'd3);
    hlt_en = 0;

    // redirect and dequeue in the same cycle with the FIFO full
    do_reset();
    repeat (8) tick(0, 0, 0, 0);
    chk("full_valid", {31'b0, out_valid}, 32'd1);
    chk("full_req", {31'b0, imem_req}, 32'd0);
    tick(1, 1, 32'h80, 0);
    chk("rdq_req", {31'b0, imem_req}, 32'd0);
    for (int k = 0; k < 6; k++) push(32'h1000_0080 + 32'(k), 32'h81 + 32'(k));
    tick(1, 0, 0, 0);
    chk("rdq_v1", {31'b0, out_valid}, 32'd0);
    tick(1, 0, 0, 0);
    chk("rdq_v2", {31'b0, out_valid}, 32'd0);
    repeat (6) tick(1, 0, 0, 0);
    chk("rdq_left", 32'(sb.size()), 32'd0);
    sb_on = 0;
    repeat (2) begin
      tick(1, 0, 0, 1);
      chk("halt_req", {31'b0, imem_req}, 32'd0);
    end

    // asynchronous reset while a request is in flight
    repeat (3) tick(1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_req", {31'b0, imem_req}, 32'd0);
    out_ready = 1'b0; halt = 1'b0;
    @(posedge clk1);
    #2 rst_n = 1'b1;
    sb_on = 1;
    push(32'h1000_0000, 1); push(32'h1000_0001, 2);
    repeat (4) tick(1, 0, 0, 0);
    chk("arst_left", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
